// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
package imem_pkg;

  // Which requester owns the response slot.
  typedef enum logic {OWN_FETCH = 1'b0, OWN_LOADER = 1'b1} owner_e;

  // addi x0,x0,0 -- handed to fetch when its address is bad.
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Word-aligned and inside the memory.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with an eligibility mask.
// Port 0 = fetch, port 1 = loader. Grant is one-hot (or zero) and is
// only ever given to a requesting, eligible port.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] eligible,
  output logic [1:0] gnt
);

  logic       last;  // 1 = port 1 won the most recent transfer
  logic [1:0] cand;

  // Pick the eligible requester; on a tie favour the one that did not win last.
  always_comb begin
    cand = req & eligible;
    gnt  = cand;
    if (&cand) gnt = last ? 2'b01 : 2'b10;
  end

  // Every grant is a transfer (ready only rises with valid), so track it directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one single-port, synchronous-read instruction memory between the
// core fetch path and the loader/debug port. Responses come back exactly
// one cycle after the grant; the response data is taken straight from the
// memory read port in that cycle.
module imem_arbiter #(
  parameter int          DEPTH     = 1024,
  parameter int          AW        = $clog2(DEPTH),
  parameter logic [31:0] NOP_INSTR = imem_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req_valid,
  output logic          fetch_req_ready,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_rsp_valid,
  output logic [31:0]   fetch_rsp_instr,
  output logic          fetch_rsp_err,
  input  logic          ld_lock,
  input  logic          ld_req_valid,
  output logic          ld_req_ready,
  input  logic          ld_req_we,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_rsp_valid,
  output logic [31:0]   ld_rsp_rdata,
  output logic          ld_rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  import imem_pkg::*;

  logic [1:0]  gnt;
  logic        sel_ld;
  logic [31:0] addr;
  logic        ok;

  // Response tag pipeline (one deep).
  logic        rsp_vld;
  owner_e      rsp_own;
  logic        rsp_err;
  logic        rsp_we;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({ld_req_valid, fetch_req_valid}),
    .eligible ({1'b1, ~ld_lock}),
    .gnt      (gnt)
  );

  assign fetch_req_ready = gnt[0];
  assign ld_req_ready    = gnt[1];
  assign sel_ld          = gnt[1];
  assign addr            = sel_ld ? ld_addr : fetch_addr;
  assign ok              = addr_ok(addr, 32'(DEPTH));

  // Issue to memory only for a granted, in-range, aligned request.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if ((|gnt) && ok) begin
      mem_en    = 1'b1;
      mem_we    = sel_ld & ld_req_we;
      mem_addr  = addr[AW+1:2];
      mem_wdata = ld_wdata;
    end
  end

  // Capture who owns next cycle's response and whether it errored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld <= 1'b0;
      rsp_own <= OWN_FETCH;
      rsp_err <= 1'b0;
      rsp_we  <= 1'b0;
    end else begin
      rsp_vld <= |gnt;
      rsp_own <= sel_ld ? OWN_LOADER : OWN_FETCH;
      rsp_err <= (|gnt) & ~ok;
      rsp_we  <= sel_ld & ld_req_we;
    end
  end

  // Steer the response to its owner; data lines are zero when not valid.
  always_comb begin
    fetch_rsp_valid = rsp_vld && (rsp_own == OWN_FETCH);
    ld_rsp_valid    = rsp_vld && (rsp_own == OWN_LOADER);
    fetch_rsp_err   = fetch_rsp_valid & rsp_err;
    ld_rsp_err      = ld_rsp_valid & rsp_err;
    fetch_rsp_instr = '0;
    ld_rsp_rdata    = '0;
    if (fetch_rsp_valid) fetch_rsp_instr = rsp_err ? NOP_INSTR : mem_rdata;
    if (ld_rsp_valid && !rsp_err && !rsp_we) ld_rsp_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural single-port memory.
// Inputs change just after the rising edge; outputs are sampled on the
// falling edge.
module tb_imem_arbiter;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req_valid, fetch_req_ready;
  logic [31:0]   fetch_addr;
  logic          fetch_rsp_valid, fetch_rsp_err;
  logic [31:0]   fetch_rsp_instr;
  logic          ld_lock, ld_req_valid, ld_req_ready, ld_req_we;
  logic [31:0]   ld_addr, ld_wdata, ld_rsp_rdata;
  logic          ld_rsp_valid, ld_rsp_err;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic [31:0]   mem [DEPTH];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_addr(fetch_addr), .fetch_rsp_valid(fetch_rsp_valid),
    .fetch_rsp_instr(fetch_rsp_instr), .fetch_rsp_err(fetch_rsp_err),
    .ld_lock(ld_lock), .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_req_we(ld_req_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_rdata(ld_rsp_rdata), .ld_rsp_err(ld_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous-read memory: a write in cycle N is visible to a read in N+1.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic to_pos;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h00000013;
    mem[0] = 32'h00500093;
    mem[1] = 32'h00600113;
    mem[2] = 32'h002081b3;
    mem[4] = 32'h11111111;
    mem[8] = 32'h22222222;

    rst_n = 1'b0;
    fetch_req_valid = 1'b0; fetch_addr = '0;
    ld_lock = 1'b0; ld_req_valid = 1'b0; ld_req_we = 1'b0;
    ld_addr = '0; ld_wdata = '0;

    // Reset state
    @(negedge clk);
    chk("rst_f_vld",  32'(fetch_rsp_valid), 32'h0);
    chk("rst_f_err",  32'(fetch_rsp_err),   32'h0);
    chk("rst_f_ins",  fetch_rsp_instr,      32'h0);
    chk("rst_l_vld",  32'(ld_rsp_valid),    32'h0);
    chk("rst_l_dat",  ld_rsp_rdata,         32'h0);
    chk("rst_mem_en", 32'(mem_en),          32'h0);
    to_pos; rst_n = 1'b1;

    // Fetch-only stream 0,4,8
    fetch_req_valid = 1'b1; fetch_addr = 32'h0;
    @(negedge clk);
    chk("f0_rdy",  32'(fetch_req_ready), 32'h1);
    chk("f0_en",   32'(mem_en),          32'h1);
    chk("f0_we",   32'(mem_we),          32'h0);
    chk("f0_addr", 32'(mem_addr),        32'h0);
    to_pos; fetch_addr = 32'h4;
    @(negedge clk);
    chk("f1_rdy",  32'(fetch_req_ready), 32'h1);
    chk("f1_addr", 32'(mem_addr),        32'h1);
    chk("f0_vld",  32'(fetch_rsp_valid), 32'h1);
    chk("f0_ins",  fetch_rsp_instr,      32'h00500093);
    chk("f0_err",  32'(fetch_rsp_err),   32'h0);
    to_pos; fetch_addr = 32'h8;
    @(negedge clk);
    chk("f2_rdy",  32'(fetch_req_ready), 32'h1);
    chk("f1_ins",  fetch_rsp_instr,      32'h00600113);
    to_pos; fetch_req_valid = 1'b0;
    @(negedge clk);
    chk("f3_rdy",  32'(fetch_req_ready), 32'h0);
    chk("f3_en",   32'(mem_en),          32'h0);
    chk("f2_ins",  fetch_rsp_instr,      32'h002081b3);
    chk("f2_vld",  32'(fetch_rsp_valid), 32'h1);
    to_pos;
    @(negedge clk);
    chk("f_idle",  32'(fetch_rsp_valid), 32'h0);

    // Reset again so the round-robin pointer starts from LOADER
    rst_n = 1'b0;
    to_pos; rst_n = 1'b1;

    // Both requesting continuously: F, L, F, L
    fetch_req_valid = 1'b1; fetch_addr = 32'h10;
    ld_req_valid = 1'b1; ld_req_we = 1'b0; ld_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_f_rdy", 32'(fetch_req_ready), 32'(i % 2 == 0));
      chk("rr_l_rdy", 32'(ld_req_ready),    32'(i % 2 == 1));
      if (i > 0) begin
        chk("rr_f_vld", 32'(fetch_rsp_valid), 32'(i % 2 == 1));
        chk("rr_l_vld", 32'(ld_rsp_valid),    32'(i % 2 == 0));
        if (i % 2 == 1) chk("rr_f_ins", fetch_rsp_instr, 32'h11111111);
        else            chk("rr_l_dat", ld_rsp_rdata,    32'h22222222);
      end
      to_pos;
    end
    fetch_req_valid = 1'b0; ld_req_valid = 1'b0;
    @(negedge clk);
    chk("rr_l_last",  ld_rsp_rdata,          32'h22222222);
    chk("rr_f_quiet", 32'(fetch_rsp_valid),  32'h0);

    // Loader lock: write 0x0 while fetch waits
    to_pos;
    ld_lock = 1'b1;
    fetch_req_valid = 1'b1; fetch_addr = 32'h0;
    ld_req_valid = 1'b1; ld_req_we = 1'b1; ld_addr = 32'h0; ld_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("lk_f_rdy", 32'(fetch_req_ready), 32'h0);
    chk("lk_l_rdy", 32'(ld_req_ready),    32'h1);
    chk("lk_we",    32'(mem_we),          32'h1);
    chk("lk_wdat",  mem_wdata,            32'hDEADBEEF);
    to_pos; ld_req_valid = 1'b0; ld_req_we = 1'b0;
    @(negedge clk);
    chk("lk_f_rdy2", 32'(fetch_req_ready), 32'h0);
    chk("lk_w_vld",  32'(ld_rsp_valid),    32'h1);
    chk("lk_w_dat",  ld_rsp_rdata,         32'h0);
    to_pos; ld_lock = 1'b0;
    @(negedge clk);
    chk("ul_f_rdy", 32'(fetch_req_ready), 32'h1);
    // Lock rises while the fetch response is pending
    to_pos; ld_lock = 1'b1; fetch_req_valid = 1'b0;
    @(negedge clk);
    chk("ul_f_vld", 32'(fetch_rsp_valid), 32'h1);
    chk("ul_f_ins", fetch_rsp_instr,      32'hDEADBEEF);
    to_pos; ld_lock = 1'b0;

    // Errors: misaligned fetch, then out-of-range loader read
    fetch_req_valid = 1'b1; fetch_addr = 32'h2;
    @(negedge clk);
    chk("ef_rdy", 32'(fetch_req_ready), 32'h1);
    chk("ef_en",  32'(mem_en),          32'h0);
    to_pos; fetch_req_valid = 1'b0;
    ld_req_valid = 1'b1; ld_req_we = 1'b0; ld_addr = 32'h1000;
    @(negedge clk);
    chk("ef_vld", 32'(fetch_rsp_valid), 32'h1);
    chk("ef_err", 32'(fetch_rsp_err),   32'h1);
    chk("ef_ins", fetch_rsp_instr,      32'h00000013);
    chk("el_rdy", 32'(ld_req_ready),    32'h1);
    chk("el_en",  32'(mem_en),          32'h0);
    to_pos; ld_req_valid = 1'b0;
    @(negedge clk);
    chk("el_vld", 32'(ld_rsp_valid), 32'h1);
    chk("el_err", 32'(ld_rsp_err),   32'h1);
    chk("el_dat", ld_rsp_rdata,      32'h0);
    to_pos;

    // Reset with a fetch response in flight
    fetch_req_valid = 1'b1; fetch_addr = 32'h4;
    @(negedge clk);
    chk("rf_rdy", 32'(fetch_req_ready), 32'h1);
    rst_n = 1'b0; fetch_req_valid = 1'b0;
    @(negedge clk);
    chk("rf_drop1", 32'(fetch_rsp_valid), 32'h0);
    to_pos; rst_n = 1'b1;
    @(negedge clk);
    chk("rf_drop2", 32'(fetch_rsp_valid), 32'h0);
    to_pos;
    fetch_req_valid = 1'b1; fetch_addr = 32'h4;
    @(negedge clk);
    chk("rf_rdy2", 32'(fetch_req_ready), 32'h1);
    to_pos; fetch_req_valid = 1'b0;
    @(negedge clk);
    chk("rf_ins", fetch_rsp_instr, 32'h00600113);
    to_pos;

    // Loader write 0x8 then fetch 0x8 the next cycle
    ld_req_valid = 1'b1; ld_req_we = 1'b1; ld_addr = 32'h8; ld_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("wf_l_rdy", 32'(ld_req_ready), 32'h1);
    chk("wf_addr",  32'(mem_addr),     32'h2);
    to_pos; ld_req_valid = 1'b0; ld_req_we = 1'b0;
    fetch_req_valid = 1'b1; fetch_addr = 32'h8;
    @(negedge clk);
    chk("wf_f_rdy", 32'(fetch_req_ready), 32'h1);
    chk("wf_l_vld", 32'(ld_rsp_valid),    32'h1);
    to_pos; fetch_req_valid = 1'b0;
    @(negedge clk);
    chk("wf_f_ins", fetch_rsp_instr, 32'hCAFEF00D);
    to_pos;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port, synchronous-read instruction memory between two requesters.
- Requester 1 is the core fetch path (read-only). Requester 2 is the program loader/debug port (read/write).
- Each port uses a valid/ready request handshake and gets a response exactly one cycle after the grant.
- Sits between the fetch stage, the loader, and the memory macro. The memory is word-addressed and holds NOP (32'h00000013) after init.

Parameters:
- DEPTH, 1024, number of 32-bit words in the memory.
- AW, $clog2(DEPTH), memory word-address width.
- NOP_INSTR, 32'h00000013, instruction returned on a fetch error (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req_valid  in  1  fetch request present.
- fetch_req_ready  out  1  fetch request granted this cycle.
- fetch_addr  in  32  byte address of the instruction.
- fetch_rsp_valid  out  1  fetch response valid.
- fetch_rsp_instr  out  32  fetched instruction.
- fetch_rsp_err  out  1  fetch address was misaligned or out of range.
- ld_lock  in  1  loader exclusive mode; fetch is never granted while high.
- ld_req_valid  in  1  loader request present.
- ld_req_ready  out  1  loader request granted this cycle.
- ld_req_we  in  1  1 = write, 0 = read.
- ld_addr  in  32  byte address.
- ld_wdata  in  32  write data.
- ld_rsp_valid  out  1  loader response valid (reads and writes both respond).
- ld_rsp_rdata  out  32  read data; 0 for writes and errors.
- ld_rsp_err  out  1  loader address was misaligned or out of range.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory word index (addr[AW+1:2]).
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid one cycle after mem_en with mem_we=0.

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - All registered outputs go to 0: rsp_valid, rsp_err, rsp data.
  - last_grant resets to LOADER, so fetch wins the first tie.
  - Any in-flight response is discarded; no response is produced for it after reset.
- Grant, evaluated combinationally each cycle:
  - ld_lock=1: only the loader is eligible.
  - Both eligible and valid: grant the port that is not last_grant (round-robin).
  - Exactly one valid: grant it.
  - At most one ready is high per cycle. ready is never high without the matching valid.
  - ready does not depend on the other port's ready.
- Handshake:
  - A transfer occurs when valid && ready. Requesters hold valid, addr, we and wdata stable until ready.
  - last_grant updates only on a transfer.
- Address check, on the granted request:
  - Error if addr[1:0] != 0 or addr[31:2] >= DEPTH.
  - Error requests do not assert mem_en. Grant and fairness still apply.
- Memory issue, same cycle as the transfer:
  - mem_en = 1 for a non-error transfer; mem_we = granted ld_req_we; mem_addr = addr[AW+1:2]; mem_wdata = ld_wdata.
  - Fetch transfers always have mem_we = 0.
  - When nothing is issued, mem_en = mem_we = 0 and the other mem outputs are don't-care, driven 0.
- Response, registered owner tag plus error flag:
  - Exactly one cycle after the transfer, the owner's rsp_valid is high for one cycle.
  - fetch: rsp_instr = NOP_INSTR if err, else mem_rdata.
  - loader read: rsp_rdata = mem_rdata, or 0 if err.
  - loader write: rsp_rdata = 0, rsp_valid = 1.
  - Response data is taken combinationally from mem_rdata in the response cycle, so there is no extra register stage. rsp_valid and rsp_err are registered.
- Throughput and ordering:
  - One transfer per cycle, back-to-back, fully pipelined.
  - There is no response backpressure; requesters must accept responses.
  - Responses come back in grant order.
- Simultaneous events:
  - A loader write and a fetch of the same address in consecutive cycles: the fetch sees the new data, because the memory is write-then-read ordered by cycle.
  - ld_lock rising while a fetch response is pending still delivers that response.
- No state machine beyond the last_grant bit and the one-deep response-tag pipeline. No counters or timeouts.

Decomposition:
- Shared package imem_pkg holds:
  - typedef enum logic {OWN_FETCH, OWN_LOADER} owner_e;
  - localparam NOP_INSTR;
  - function addr_ok(addr, depth).
- Natural sub-module: rr_arb2, a 2-requester round-robin arbiter with mask (lock) input and last_grant register, outputting a one-hot grant.

Test Plan:
- Reset, then fetch only: fetch_addr 0, 4, 8 back-to-back with mem preloaded 00500093/00600113/002081b3 -> ready each cycle; rsp_valid on cycles+1 with those words in order; err=0.
- Both valid continuously (fetch addr 0x10, loader read 0x20) -> first grant fetch, then alternating L,F,L,F; each response appears on the correct port one cycle later.
- ld_lock=1 with both valid -> fetch_req_ready stays 0; loader write 0x0 = 32'hDEADBEEF, rsp_rdata=0; release lock; fetch 0x0 -> instr DEADBEEF.
- Errors: fetch 0x2 -> mem_en=0, rsp_err=1, instr 00000013; loader read 0x1000 (DEPTH=1024) -> ld_rsp_err=1, rdata 0.
- Assert rst_n=0 the cycle after a granted fetch -> no fetch_rsp_valid at any time after reset; next fetch after reset behaves normally.
- Loader write to 0x8 followed next cycle by fetch 0x8 -> fetch returns the written value.
